// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word loads with sign/zero extension, sub-word stores via read-merge-write.
// Optional misalignment trap enabled by defining LSU_MISALIGN_TRAP_EN.
`ifndef DWIDTH
`define DWIDTH 32
`endif
`ifndef AWIDTH_MEM
`define AWIDTH_MEM 10
`endif

module load_store_unit (
  input  logic                   ls_clk,
  input  logic                   ls_rst,
  input  logic                   ls_i_valid,
  input  logic                   ls_i_load,
  input  logic                   ls_i_store,
  input  logic [1:0]             ls_i_size,
  input  logic                   ls_i_unsigned,
  input  logic [31:0]            ls_i_addr,
  input  logic [`DWIDTH-1:0]     ls_i_store_data,
  output logic                   ls_o_mem_ce,
  output logic                   ls_o_mem_rd_en,
  output logic                   ls_o_mem_wr_en,
  output logic [`AWIDTH_MEM-1:0] ls_o_mem_addr,
  output logic [`DWIDTH-1:0]     ls_o_mem_wdata,
  input  logic [`DWIDTH-1:0]     ls_i_mem_rdata,
  output logic                   ls_o_stall,
  output logic                   ls_o_valid,
  output logic [`DWIDTH-1:0]     ls_o_load_data,
`ifdef LSU_MISALIGN_TRAP_EN
  output logic                   ls_o_misalign,
`endif
  output logic                   ls_o_dbg_state
);

  localparam int DW = `DWIDTH;
  localparam int AW = `AWIDTH_MEM;

  typedef enum logic {S_IDLE = 1'b0, S_MERGE = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] wbuf_q, wbuf_d;
  logic [DW-1:0] load_data_q, load_data_d;
  logic          valid_q, valid_d;
  logic          misalign_q, misalign_d;

  logic          is_load, is_store, is_byte, is_half, is_word, misaligned;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [DW-1:0] load_ext, merged;
  logic          unused_ok;

  assign unused_ok = ^{ls_i_addr[31:AW+2]};

  // Lane extraction/insertion; sub-word offsets come from the low address bits (aligned down).
  always_comb begin
    is_store = ls_i_valid & ls_i_store;
    is_load  = ls_i_valid & ls_i_load & ~ls_i_store;
    is_byte  = (ls_i_size == 2'b00);
    is_half  = (ls_i_size == 2'b01);
    is_word  = ls_i_size[1];
    rd_byte  = ls_i_mem_rdata[{ls_i_addr[1:0], 3'b000} +: 8];
    rd_half  = ls_i_mem_rdata[{ls_i_addr[1], 4'b0000} +: 16];
    if (is_byte)
      load_ext = {{(DW-8){rd_byte[7] & ~ls_i_unsigned}}, rd_byte};
    else if (is_half)
      load_ext = {{(DW-16){rd_half[15] & ~ls_i_unsigned}}, rd_half};
    else
      load_ext = ls_i_mem_rdata;
    merged = ls_i_mem_rdata;
    if (is_byte)
      merged[{ls_i_addr[1:0], 3'b000} +: 8] = ls_i_store_data[7:0];
    else
      merged[{ls_i_addr[1], 4'b0000} +: 16] = ls_i_store_data[15:0];
`ifdef LSU_MISALIGN_TRAP_EN
    misaligned = (is_half & ls_i_addr[0]) | (is_word & (|ls_i_addr[1:0]));
`else
    misaligned = 1'b0;
`endif
  end

  // Upstream handshake: a request is presented with ls_i_valid and is held stable while
  // ls_o_stall=1; it is consumed at the first posedge where ls_o_stall=0.
  always_comb begin
    state_d        = state_q;
    wbuf_d         = wbuf_q;
    load_data_d    = load_data_q;
    valid_d        = 1'b0;
    misalign_d     = 1'b0;
    ls_o_mem_ce    = 1'b0;
    ls_o_mem_rd_en = 1'b0;
    ls_o_mem_wr_en = 1'b0;
    ls_o_mem_wdata = '0;
    ls_o_stall     = 1'b0;
    ls_o_mem_addr  = ls_i_addr[AW+1:2];
    if (ls_rst) begin
      case (state_q)
        S_IDLE: begin
          if (is_load || is_store) begin
            if (misaligned) begin
              valid_d     = 1'b1;
              misalign_d  = 1'b1;
              load_data_d = '0;
            end else if (is_load) begin
              ls_o_mem_ce    = 1'b1;
              ls_o_mem_rd_en = 1'b1;
              valid_d        = 1'b1;
              load_data_d    = load_ext;
            end else if (is_word) begin
              ls_o_mem_ce    = 1'b1;
              ls_o_mem_wr_en = 1'b1;
              ls_o_mem_wdata = ls_i_store_data;
              valid_d        = 1'b1;
            end else begin
              ls_o_mem_ce    = 1'b1;
              ls_o_mem_rd_en = 1'b1;
              ls_o_stall     = 1'b1;
              wbuf_d         = merged;
              state_d        = S_MERGE;
            end
          end
        end
        S_MERGE: begin
          ls_o_mem_ce    = 1'b1;
          ls_o_mem_wr_en = 1'b1;
          ls_o_mem_wdata = wbuf_q;
          valid_d        = 1'b1;
          state_d        = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge ls_clk or negedge ls_rst) begin
    if (!ls_rst) begin
      state_q     <= S_IDLE;
      wbuf_q      <= '0;
      load_data_q <= '0;
      valid_q     <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wbuf_q      <= wbuf_d;
      load_data_q <= load_data_d;
      valid_q     <= valid_d;
      misalign_q  <= misalign_d;
    end
  end

  assign ls_o_valid     = valid_q;
  assign ls_o_load_data = load_data_q;
  assign ls_o_dbg_state = state_q;
`ifdef LSU_MISALIGN_TRAP_EN
  assign ls_o_misalign  = misalign_q;
`else
  logic unused_misalign;
  assign unused_misalign = misalign_q;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit with a behavioural word memory preloaded word[n]=n.
// Covers both builds; misalignment expectations follow LSU_MISALIGN_TRAP_EN.
module tb_load_store_unit;
  localparam int AW = 10;

  logic        ls_clk = 1'b0;
  logic        ls_rst = 1'b0;
  logic        ls_i_valid, ls_i_load, ls_i_store, ls_i_unsigned;
  logic [1:0]  ls_i_size;
  logic [31:0] ls_i_addr, ls_i_store_data;
  logic        ls_o_mem_ce, ls_o_mem_rd_en, ls_o_mem_wr_en;
  logic [AW-1:0] ls_o_mem_addr;
  logic [31:0] ls_o_mem_wdata, ls_i_mem_rdata;
  logic        ls_o_stall, ls_o_valid, ls_o_dbg_state;
  logic [31:0] ls_o_load_data;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        ls_o_misalign;
`endif

  logic [31:0] mem [0:(1<<AW)-1];
  int checks = 0;
  int failures = 0;

  load_store_unit dut (
    .ls_clk(ls_clk), .ls_rst(ls_rst), .ls_i_valid(ls_i_valid), .ls_i_load(ls_i_load),
    .ls_i_store(ls_i_store), .ls_i_size(ls_i_size), .ls_i_unsigned(ls_i_unsigned),
    .ls_i_addr(ls_i_addr), .ls_i_store_data(ls_i_store_data), .ls_o_mem_ce(ls_o_mem_ce),
    .ls_o_mem_rd_en(ls_o_mem_rd_en), .ls_o_mem_wr_en(ls_o_mem_wr_en),
    .ls_o_mem_addr(ls_o_mem_addr), .ls_o_mem_wdata(ls_o_mem_wdata),
    .ls_i_mem_rdata(ls_i_mem_rdata), .ls_o_stall(ls_o_stall), .ls_o_valid(ls_o_valid),
    .ls_o_load_data(ls_o_load_data),
`ifdef LSU_MISALIGN_TRAP_EN
    .ls_o_misalign(ls_o_misalign),
`endif
    .ls_o_dbg_state(ls_o_dbg_state)
  );

  // clock / memory model
  always #5 ls_clk = ~ls_clk;
  assign ls_i_mem_rdata = mem[ls_o_mem_addr];
  always @(posedge ls_clk) begin
    if (ls_o_mem_ce && ls_o_mem_wr_en) mem[ls_o_mem_addr] = ls_o_mem_wdata;
  end

  // driver tasks
  task automatic drive(input logic v, input logic ld, input logic st, input logic [1:0] sz,
                       input logic uns, input logic [31:0] a, input logic [31:0] d);
    ls_i_valid = v; ls_i_load = ld; ls_i_store = st; ls_i_size = sz;
    ls_i_unsigned = uns; ls_i_addr = a; ls_i_store_data = d;
  endtask

  task automatic idle_in();
    drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic cycle();
    @(posedge ls_clk);
    @(negedge ls_clk);
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
    @(negedge ls_clk); #1;
    checks++; if (ls_o_mem_ce !== 1'b0) begin failures++; $display("FAIL rst_ce got=%0b exp=0", ls_o_mem_ce); end
    checks++; if (ls_o_mem_rd_en !== 1'b0) begin failures++; $display("FAIL rst_rd got=%0b exp=0", ls_o_mem_rd_en); end
    checks++; if (ls_o_stall !== 1'b0) begin failures++; $display("FAIL rst_stall got=%0b exp=0", ls_o_stall); end
    checks++; if (ls_o_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0b exp=0", ls_o_valid); end
    checks++; if (ls_o_load_data !== 32'h0) begin failures++; $display("FAIL rst_data got=%h exp=0", ls_o_load_data); end
    checks++; if (ls_o_dbg_state !== 1'b0) begin failures++; $display("FAIL rst_state got=%0b exp=0", ls_o_dbg_state); end
`ifdef LSU_MISALIGN_TRAP_EN
    checks++; if (ls_o_misalign !== 1'b0) begin failures++; $display("FAIL rst_misalign got=%0b exp=0", ls_o_misalign); end
`endif
    idle_in();
    ls_rst = 1'b1;
    cycle();
  endtask

  task automatic test_load_word();
    drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
    #1;
    checks++; if (ls_o_mem_ce !== 1'b1) begin failures++; $display("FAIL lw_ce got=%0b exp=1", ls_o_mem_ce); end
    checks++; if (ls_o_mem_rd_en !== 1'b1) begin failures++; $display("FAIL lw_rd got=%0b exp=1", ls_o_mem_rd_en); end
    checks++; if (ls_o_mem_wr_en !== 1'b0) begin failures++; $display("FAIL lw_wr got=%0b exp=0", ls_o_mem_wr_en); end
    checks++; if (ls_o_stall !== 1'b0) begin failures++; $display("FAIL lw_stall got=%0b exp=0", ls_o_stall); end
    checks++; if (ls_o_mem_addr !== 10'd5) begin failures++; $display("FAIL lw_addr got=%0d exp=5", ls_o_mem_addr); end
    cycle(); idle_in(); #1;
    checks++; if (ls_o_valid !== 1'b1) begin failures++; $display("FAIL lw_valid got=%0b exp=1", ls_o_valid); end
    checks++; if (ls_o_load_data !== 32'h5) begin failures++; $display("FAIL lw_data got=%h exp=00000005", ls_o_load_data); end
    cycle();
    checks++; if (ls_o_valid !== 1'b0) begin failures++; $display("FAIL lw_pulse got=%0b exp=0", ls_o_valid); end
  endtask

  task automatic test_store_word();
    drive(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h14, 32'h8899AABB);
    #1;
    checks++; if (ls_o_mem_wr_en !== 1'b1) begin failures++; $display("FAIL sw_wr got=%0b exp=1", ls_o_mem_wr_en); end
    checks++; if (ls_o_mem_rd_en !== 1'b0) begin failures++; $display("FAIL sw_rd got=%0b exp=0", ls_o_mem_rd_en); end
    checks++; if (ls_o_mem_wdata !== 32'h8899AABB) begin failures++; $display("FAIL sw_wdata got=%h exp=8899aabb", ls_o_mem_wdata); end
    checks++; if (ls_o_stall !== 1'b0) begin failures++; $display("FAIL sw_stall got=%0b exp=0", ls_o_stall); end
    cycle(); idle_in(); #1;
    checks++; if (ls_o_valid !== 1'b1) begin failures++; $display("FAIL sw_valid got=%0b exp=1", ls_o_valid); end
    checks++; if (ls_o_load_data !== 32'h5) begin failures++; $display("FAIL sw_data_kept got=%h exp=00000005", ls_o_load_data); end
    checks++; if (mem[5] !== 32'h8899AABB) begin failures++; $display("FAIL sw_mem got=%h exp=8899aabb", mem[5]); end
    cycle();
  endtask

  task automatic test_subword_loads();
    logic [31:0] addrs [6] = '{32'h15, 32'h15, 32'h16, 32'h14, 32'h17, 32'h14};
    logic [1:0]  sizes [6] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00};
    logic        unss  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] exps  [6] = '{32'hFFFFFFAA, 32'h000000AA, 32'hFFFF8899, 32'h0000AABB,
                               32'hFFFFFF88, 32'hFFFFFFBB};
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, 1'b0, sizes[i], unss[i], addrs[i], 32'h0);
      cycle();
      if (i == 5) idle_in();
      #1;
      checks++; if (ls_o_valid !== 1'b1) begin failures++; $display("FAIL sub_valid[%0d] got=%0b exp=1", i, ls_o_valid); end
      checks++; if (ls_o_load_data !== exps[i]) begin failures++; $display("FAIL sub_data[%0d] got=%h exp=%h", i, ls_o_load_data, exps[i]); end
      @(negedge ls_clk);
    end
    cycle();
  endtask

  task automatic test_reset_in_merge();
    drive(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 32'h14, 32'h000000EE);
    #1;
    checks++; if (ls_o_stall !== 1'b1) begin failures++; $display("FAIL sbr_stall got=%0b exp=1", ls_o_stall); end
    cycle(); #1;
    checks++; if (ls_o_dbg_state !== 1'b1) begin failures++; $display("FAIL sbr_merge got=%0b exp=1", ls_o_dbg_state); end
    checks++; if (ls_o_mem_wdata !== 32'h8899AAEE) begin failures++; $display("FAIL sbr_wdata got=%h exp=8899aaee", ls_o_mem_wdata); end
    ls_rst = 1'b0; #1;
    checks++; if (ls_o_mem_wr_en !== 1'b0) begin failures++; $display("FAIL sbr_wr got=%0b exp=0", ls_o_mem_wr_en); end
    checks++; if (ls_o_mem_ce !== 1'b0) begin failures++; $display("FAIL sbr_ce got=%0b exp=0", ls_o_mem_ce); end
    checks++; if (ls_o_dbg_state !== 1'b0) begin failures++; $display("FAIL sbr_state got=%0b exp=0", ls_o_dbg_state); end
    checks++; if (ls_o_load_data !== 32'h0) begin failures++; $display("FAIL sbr_data got=%h exp=0", ls_o_load_data); end
    checks++; if (ls_o_valid !== 1'b0) begin failures++; $display("FAIL sbr_valid got=%0b exp=0", ls_o_valid); end
    idle_in();
    cycle();
    ls_rst = 1'b1;
    cycle();
    checks++; if (mem[5] !== 32'h8899AABB) begin failures++; $display("FAIL sbr_mem got=%h exp=8899aabb", mem[5]); end
  endtask

  task automatic test_store_half();
    drive(1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 32'h16, 32'h00001234);
    #1;
    checks++; if (ls_o_stall !== 1'b1) begin failures++; $display("FAIL sh_stall got=%0b exp=1", ls_o_stall); end
    checks++; if (ls_o_mem_rd_en !== 1'b1) begin failures++; $display("FAIL sh_rd got=%0b exp=1", ls_o_mem_rd_en); end
    checks++; if (ls_o_mem_wr_en !== 1'b0) begin failures++; $display("FAIL sh_rd_wr got=%0b exp=0", ls_o_mem_wr_en); end
    cycle(); #1;
    checks++; if (ls_o_stall !== 1'b0) begin failures++; $display("FAIL sh_merge_stall got=%0b exp=0", ls_o_stall); end
    checks++; if (ls_o_mem_wr_en !== 1'b1) begin failures++; $display("FAIL sh_wr got=%0b exp=1", ls_o_mem_wr_en); end
    checks++; if (ls_o_mem_wdata !== 32'h1234AABB) begin failures++; $display("FAIL sh_wdata got=%h exp=1234aabb", ls_o_mem_wdata); end
    checks++; if (ls_o_mem_addr !== 10'd5) begin failures++; $display("FAIL sh_addr got=%0d exp=5", ls_o_mem_addr); end
    checks++; if (ls_o_valid !== 1'b0) begin failures++; $display("FAIL sh_early_valid got=%0b exp=0", ls_o_valid); end
    cycle(); idle_in(); #1;
    checks++; if (ls_o_valid !== 1'b1) begin failures++; $display("FAIL sh_valid got=%0b exp=1", ls_o_valid); end
    checks++; if (mem[5] !== 32'h1234AABB) begin failures++; $display("FAIL sh_mem got=%h exp=1234aabb", mem[5]); end
    checks++; if (ls_o_load_data !== 32'h0) begin failures++; $display("FAIL sh_data_kept got=%h exp=0", ls_o_load_data); end
    cycle();
    drive(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 32'h17, 32'h0000005A);
    cycle(); cycle(); idle_in();
    checks++; if (mem[5] !== 32'h5A34AABB) begin failures++; $display("FAIL sb_mem got=%h exp=5a34aabb", mem[5]); end
    cycle();
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    cycle();
    drive(1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 32'h24, 32'h0);
    #1;
    checks++; if (ls_o_load_data !== 32'h8) begin failures++; $display("FAIL b2b_first got=%h exp=00000008", ls_o_load_data); end
    checks++; if (ls_o_mem_addr !== 10'd9) begin failures++; $display("FAIL b2b_addr got=%0d exp=9", ls_o_mem_addr); end
    cycle(); idle_in(); #1;
    checks++; if (ls_o_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid got=%0b exp=1", ls_o_valid); end
    checks++; if (ls_o_load_data !== 32'h9) begin failures++; $display("FAIL b2b_second got=%h exp=00000009", ls_o_load_data); end
    cycle();
  endtask

  task automatic test_load_and_store();
    drive(1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D);
    #1;
    checks++; if (ls_o_mem_wr_en !== 1'b1) begin failures++; $display("FAIL both_wr got=%0b exp=1", ls_o_mem_wr_en); end
    checks++; if (ls_o_mem_rd_en !== 1'b0) begin failures++; $display("FAIL both_rd got=%0b exp=0", ls_o_mem_rd_en); end
    cycle(); idle_in(); #1;
    checks++; if (ls_o_valid !== 1'b1) begin failures++; $display("FAIL both_valid got=%0b exp=1", ls_o_valid); end
    checks++; if (ls_o_load_data !== 32'h9) begin failures++; $display("FAIL both_data got=%h exp=00000009", ls_o_load_data); end
    checks++; if (mem[8] !== 32'hCAFEF00D) begin failures++; $display("FAIL both_mem got=%h exp=cafef00d", mem[8]); end
    cycle();
  endtask

  task automatic test_no_op();
    drive(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'hFFFFFFFF);
    #1;
    checks++; if ({ls_o_mem_ce, ls_o_mem_rd_en, ls_o_mem_wr_en, ls_o_stall} !== 4'b0) begin
      failures++; $display("FAIL noop_ctrl got=%b exp=0000", {ls_o_mem_ce, ls_o_mem_rd_en, ls_o_mem_wr_en, ls_o_stall}); end
    cycle(); idle_in(); #1;
    checks++; if (ls_o_valid !== 1'b0) begin failures++; $display("FAIL noop_valid got=%0b exp=0", ls_o_valid); end
    checks++; if (mem[4] !== 32'h4) begin failures++; $display("FAIL noop_mem got=%h exp=00000004", mem[4]); end
    cycle();
  endtask

  task automatic test_misalign();
    drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h15, 32'h0);
    #1;
`ifdef LSU_MISALIGN_TRAP_EN
    checks++; if (ls_o_mem_ce !== 1'b0) begin failures++; $display("FAIL mis_ce got=%0b exp=0", ls_o_mem_ce); end
    checks++; if (ls_o_stall !== 1'b0) begin failures++; $display("FAIL mis_stall got=%0b exp=0", ls_o_stall); end
    cycle(); idle_in(); #1;
    checks++; if (ls_o_valid !== 1'b1) begin failures++; $display("FAIL mis_valid got=%0b exp=1", ls_o_valid); end
    checks++; if (ls_o_misalign !== 1'b1) begin failures++; $display("FAIL mis_flag got=%0b exp=1", ls_o_misalign); end
    checks++; if (ls_o_load_data !== 32'h0) begin failures++; $display("FAIL mis_data got=%h exp=0", ls_o_load_data); end
    cycle();
    checks++; if (ls_o_misalign !== 1'b0) begin failures++; $display("FAIL mis_pulse got=%0b exp=0", ls_o_misalign); end
`else
    checks++; if (ls_o_mem_ce !== 1'b1) begin failures++; $display("FAIL mis_ce got=%0b exp=1", ls_o_mem_ce); end
    checks++; if (ls_o_mem_addr !== 10'd5) begin failures++; $display("FAIL mis_addr got=%0d exp=5", ls_o_mem_addr); end
    cycle(); idle_in(); #1;
    checks++; if (ls_o_valid !== 1'b1) begin failures++; $display("FAIL mis_valid got=%0b exp=1", ls_o_valid); end
    checks++; if (ls_o_load_data !== 32'h5A34AABB) begin failures++; $display("FAIL mis_data got=%h exp=5a34aabb", ls_o_load_data); end
    cycle();
`endif
  endtask

  initial begin
    for (int n = 0; n < (1 << AW); n++) mem[n] = n;
    idle_in();
    test_reset();
    test_load_word();
    test_store_word();
    test_subword_loads();
    test_reset_in_merge();
    test_store_half();
    test_back_to_back();
    test_load_and_store();
    test_no_op();
    test_misalign();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
